// File: rtl/lod_normalize.sv
// rtl/lod_normalize.sv - 3-stage leading-one normalizer; LOD_NORMALIZE_ZERO_DROP_EN drops all-zero words at S2.
module lod_normalize #(
    parameter int DATA_W  = 16,
    parameter int SHIFT_W = $clog2(DATA_W)
) (
    input  logic               aclk,
    input  logic               areset,
    input  logic               rx_valid,
    output logic               rx_ready,
    input  logic [DATA_W-1:0]  rx_data,
    output logic               tx_valid,
    input  logic               tx_ready,
    output logic [DATA_W-1:0]  tx_data,
    output logic [SHIFT_W-1:0] tx_shift,
    output logic               tx_zero
);
    localparam int NG = DATA_W / 4;

    generate
        if (DATA_W != 8 && DATA_W != 16 && DATA_W != 32) begin : g_bad_width
            $error("lod_normalize: DATA_W must be 8, 16 or 32");
        end
        if (SHIFT_W != $clog2(DATA_W)) begin : g_bad_shift_w
            $error("lod_normalize: SHIFT_W is derived from DATA_W and must not be overridden");
        end
    endgenerate

    logic                     v1, v2, v3;
    logic [DATA_W-1:0]        w1, w2, d3;
    logic [NG-1:0]            hot1;
    logic [NG-1:0][1:0]       pos1;
    logic [SHIFT_W-1:0]       sh2, sh3;
    logic                     z2, z3;
    logic                     load1, load2, load3;

    // Each stage may load when it is empty or its successor is loading this cycle.
    assign load3    = !v3 || tx_ready;
    assign load2    = !v2 || load3;
    assign load1    = !v1 || load2;
    assign rx_ready = load1;

    logic [NG-1:0]      grp_hot;
    logic [NG-1:0][1:0] grp_pos;

    always_comb begin
        for (int g = 0; g < NG; g++) begin
            grp_hot[g] = |rx_data[4*g +: 4];
            grp_pos[g] = rx_data[4*g+3] ? 2'd3 :
                         rx_data[4*g+2] ? 2'd2 :
                         rx_data[4*g+1] ? 2'd1 : 2'd0;
        end
    end

    logic               any_hot;
    logic [SHIFT_W-1:0] lead_pos;
    logic [SHIFT_W-1:0] lead_shift;

    // Ascending scan so the highest hot group wins the last assignment.
    always_comb begin
        any_hot  = 1'b0;
        lead_pos = '1;
        for (int g = 0; g < NG; g++) begin
            if (hot1[g]) begin
                any_hot  = 1'b1;
                lead_pos = {(SHIFT_W-2)'(g), pos1[g]};
            end
        end
        lead_shift = any_hot ? (SHIFT_W'(DATA_W - 1) - lead_pos) : '0;
    end

    logic keep2;
    logic zero2;
`ifdef LOD_NORMALIZE_ZERO_DROP_EN
    assign keep2 = any_hot;
    assign zero2 = 1'b0;
`else
    assign keep2 = 1'b1;
    assign zero2 = !any_hot;
`endif

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            v1   <= 1'b0;
            v2   <= 1'b0;
            v3   <= 1'b0;
            w1   <= '0;
            hot1 <= '0;
            pos1 <= '0;
            w2   <= '0;
            sh2  <= '0;
            z2   <= 1'b0;
            d3   <= '0;
            sh3  <= '0;
            z3   <= 1'b0;
        end else begin
            if (load1) begin
                v1 <= rx_valid;
                if (rx_valid) begin
                    w1   <= rx_data;
                    hot1 <= grp_hot;
                    pos1 <= grp_pos;
                end
            end
            if (load2) begin
                v2 <= v1 && keep2;
                if (v1) begin
                    w2  <= w1;
                    sh2 <= lead_shift;
                    z2  <= zero2;
                end
            end
            if (load3) begin
                v3 <= v2;
                if (v2) begin
                    d3  <= w2 << sh2;
                    sh3 <= sh2;
                    z3  <= z2;
                end
            end
        end
    end

    assign tx_valid = v3;
    assign tx_data  = d3;
    assign tx_shift = sh3;
    assign tx_zero  = z3;

endmodule

// File: tb/tb_lod_normalize.sv
// tb/tb_lod_normalize.sv - directed and random bench for lod_normalize (DATA_W=16).
module tb_lod_normalize;
    logic        aclk;
    logic        areset;
    logic        rx_valid;
    logic        rx_ready;
    logic [15:0] rx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [15:0] tx_data;
    logic [3:0]  tx_shift;
    logic        tx_zero;

    lod_normalize #(.DATA_W(16)) dut (
        .aclk     (aclk),
        .areset   (areset),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .rx_data  (rx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .tx_data  (tx_data),
        .tx_shift (tx_shift),
        .tx_zero  (tx_zero)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    typedef struct packed {
        logic [15:0] data;
        logic [3:0]  shift;
        logic        zero;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    function automatic exp_t model(input logic [15:0] d);
        exp_t e;
        e.zero  = (d == 16'h0000);
        e.shift = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (d[i]) begin
                e.shift = 4'(15 - i);
                break;
            end
        end
        e.data = d << e.shift;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: push on input transfer, pop and compare on output transfer.
    always @(negedge aclk) begin
        if (!areset) begin
            if (tx_valid && tx_ready) begin
                checks++;
                assert (sb.size() != 0) else begin
                    errors++;
                    $error("FAIL unexpected_out observed %0h expected none", tx_data);
                end
                if (sb.size() != 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("sb_data", tx_data, e.data);
                    chk("sb_shift", tx_shift, e.shift);
                    chk("sb_zero", tx_zero, e.zero);
                    if (!e.zero) chk("sb_msb", tx_data[15], 1);
                end
            end
            if (rx_valid && rx_ready) sb.push_back(model(rx_data));
        end
    end

    task automatic send(input logic [15:0] d);
        bit ok;
        ok = 1'b0;
        rx_valid = 1'b1;
        rx_data  = d;
        for (int n = 0; n < 200; n++) begin
            @(negedge aclk);
            if (rx_ready) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge aclk);
        #1;
        rx_valid = 1'b0;
        chk("send_accept", ok, 1);
    endtask

    task automatic wait_valid(input string tag);
        for (int n = 0; n < 50; n++) begin
            @(negedge aclk);
            if (tx_valid) break;
        end
        chk(tag, tx_valid, 1);
    endtask

    task automatic drain();
        for (int n = 0; n < 500 && sb.size() != 0; n++) begin
            @(negedge aclk);
            #1;
        end
        chk("drain", sb.size(), 0);
        @(posedge aclk);
        #1;
    endtask

    initial begin
        int  n;
        int  sent;
        int  cyc;
        bit  acc;

        areset   = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 16'h0000;
        tx_ready = 1'b1;

        @(negedge aclk);
        chk("rst_tx_valid", tx_valid, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_tx_shift", tx_shift, 0);
        chk("rst_tx_zero", tx_zero, 0);
        @(posedge aclk);
        #1;
        areset = 1'b0;
        @(negedge aclk);
        chk("post_rst_rx_ready", rx_ready, 1);

        // Single word, latency
        @(posedge aclk);
        #1;
        send(16'h0001);
        for (n = 0; n < 10; n++) begin
            @(negedge aclk);
            if (tx_valid) break;
        end
        chk("latency", n, 2);
        chk("t1_data", tx_data, 16'h8000);
        chk("t1_shift", tx_shift, 15);
        chk("t1_zero", tx_zero, 0);
        drain();

        // Back-to-back
        send(16'h8000);
        send(16'h00F3);
        wait_valid("b2b_valid0");
        chk("b2b_data0", tx_data, 16'h8000);
        chk("b2b_shift0", tx_shift, 0);
        @(negedge aclk);
        chk("b2b_valid1", tx_valid, 1);
        chk("b2b_data1", tx_data, 16'hF300);
        chk("b2b_shift1", tx_shift, 8);
        drain();

        // Zero word
        send(16'h0000);
        wait_valid("zero_valid");
        chk("zero_data", tx_data, 0);
        chk("zero_shift", tx_shift, 0);
        chk("zero_flag", tx_zero, 1);
        drain();

        // Backpressure
        tx_ready = 1'b0;
        send(16'h1000);
        send(16'h0100);
        send(16'h0010);
        @(negedge aclk);
        chk("bp_rx_ready_full", rx_ready, 0);
        chk("bp_valid", tx_valid, 1);
        chk("bp_data", tx_data, 16'h8000);
        chk("bp_shift", tx_shift, 3);
        @(posedge aclk);
        #1;
        rx_valid = 1'b1;
        rx_data  = 16'h0001;
        repeat (4) @(posedge aclk);
        @(negedge aclk);
        chk("bp_rx_ready_hold", rx_ready, 0);
        chk("bp_data_hold", tx_data, 16'h8000);
        chk("bp_shift_hold", tx_shift, 3);
        chk("bp_sb_depth", sb.size(), 3);
        @(posedge aclk);
        #1;
        tx_ready = 1'b1;
        send(16'h0001);
        drain();

        // Random valid/ready
        sent = 0;
        cyc  = 0;
        rx_valid = 1'b0;
        while (sent < 10000 && cyc < 80000) begin
            @(negedge aclk);
            acc = rx_valid && rx_ready;
            @(posedge aclk);
            #1;
            cyc++;
            if (acc) sent++;
            if (!rx_valid || acc) begin
                rx_valid = ($urandom_range(0, 3) != 0);
                rx_data  = 16'(32'($urandom) >> $urandom_range(16, 32));
            end
            tx_ready = ($urandom_range(0, 3) != 0);
        end
        rx_valid = 1'b0;
        tx_ready = 1'b1;
        chk("rand_sent", sent, 10000);
        drain();

        // Reset with words in flight
        send(16'h1234);
        send(16'h0F00);
        areset = 1'b1;
        #1;
        chk("rst_flight_valid", tx_valid, 0);
        chk("rst_flight_data", tx_data, 0);
        sb.delete();
        @(posedge aclk);
        #1;
        areset = 1'b0;
        send(16'h0002);
        wait_valid("after_rst_valid");
        chk("after_rst_shift", tx_shift, 14);
        chk("after_rst_data", tx_data, 16'h8000);
        repeat (10) @(negedge aclk);
        chk("after_rst_sb", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/lod_normalize.md
Name: lod_normalize

Overview:
- Pipelined leading-one normalizer that sits directly downstream of the 4-bit leading-one detector groups.
- Accepts a DATA_W-bit word per handshake and splits it into 4-bit groups. Each group produces a hot flag and a 2-bit position.
- Combines the groups into a leading-zero count, then left-shifts the word so its leading one lands at the MSB.
- Feeds the mantissa/exponent path with the normalized word, the shift count and a zero flag.

Parameters:
- DATA_W, 16, input word width. Must be a multiple of 4 in {8, 16, 32}; any other value is an elaboration error.
- SHIFT_W, $clog2(DATA_W), width of the shift count. Derived; must not be overridden.

Ports:
- aclk  input  1  clock; all logic on the rising edge.
- areset  input  1  asynchronous, active-high reset.
- rx_valid  input  1  input word valid.
- rx_ready  output  1  block can accept an input word.
- rx_data  input  DATA_W  word to normalize.
- tx_valid  output  1  output result valid.
- tx_ready  input  1  downstream accepts the result.
- tx_data  output  DATA_W  normalized word; MSB set unless tx_zero.
- tx_shift  output  SHIFT_W  leading-zero count = left-shift amount applied.
- tx_zero  output  1  input word was all zeros.

Behaviour:
- Reset: one clock; areset is asynchronous, active-high. While areset is high:
  - all stage valids clear; tx_valid=0;
  - tx_data=0, tx_shift=0, tx_zero=0;
  - rx_ready=1 on the first cycle after release.
  - Reset asserted mid-operation discards every in-flight word; nothing is emitted afterwards for those words.
- Handshakes:
  - Transfer in occurs when rx_valid & rx_ready.
  - Transfer out occurs when tx_valid & tx_ready.
  - rx_data is sampled only on a transfer.
- Pipeline: 3 register stages, S1 -> S2 -> S3. Latency is exactly 3 cycles from input transfer to tx_valid when tx_ready is held high. Throughput is 1 word/cycle.
  - S1: registers the word, plus per-group hot flag and 2-bit in-group position. The group covering bits [4g+3:4g] has flag = OR of its bits and position = index of its highest set bit.
  - S2: selects the highest hot group g. Position p = 4g + group position. tx_shift = DATA_W-1-p. Zero = no group hot.
  - S3: tx_data = word << shift.
  - Zero input: tx_data=0, tx_shift=0, tx_zero=1.
- Stall rule, per stage k:
  - load_k = !valid_k | load_(k+1); load_4 = tx_ready.
  - rx_ready = load_1, combinational from stage state and tx_ready only. No combinational path from rx_valid to rx_ready.
  - Bubbles collapse: an empty stage accepts new data even while the output is stalled.
- Backpressure: while tx_valid & !tx_ready, tx_data, tx_shift and tx_zero hold stable. With all 3 stages full and tx_ready=0, rx_ready=0.
- Simultaneous in/out on a full pipe: with tx_ready=1 and rx_valid=1, the pipe advances and accepts in the same cycle; no loss, no duplication.
- Ordering: strictly in order; no reordering.
- Arithmetic: tx_shift is unsigned, range 0..DATA_W-1. Bits shifted out are discarded; zeros fill from the LSB.

Optional Feature:
- Macro: LOD_NORMALIZE_ZERO_DROP_EN.
- Defined:
  - all-zero input words are accepted (rx_ready unchanged) but invalidated at S2;
  - they never reach the output and tx_zero is tied to 0;
  - a dropped word frees its slot, so a following word advances into it normally.
- Undefined: zero words pass through with tx_zero=1 as described above.

Test Plan (DATA_W=16, tx_ready=1 unless stated):
- 0x0001 -> after 3 cycles: tx_data=0x8000, tx_shift=15, tx_zero=0.
- 0x8000 -> tx_data=0x8000, tx_shift=0. Then 0x00F3 -> tx_data=0xF300, tx_shift=8. Back-to-back, results on consecutive cycles.
- 0x0000 -> tx_data=0x0000, tx_shift=0, tx_zero=1. With LOD_NORMALIZE_ZERO_DROP_EN: no tx_valid for it, and a following 0x0400 emerges with tx_shift=5.
- tx_ready=0; stream 0x1000, 0x0100, 0x0010, 0x0001:
  - rx_ready drops after 3 accepts;
  - outputs hold 0x8000/shift 3 stable;
  - release -> outputs in order: shift 3, 7, 11, 15.
- Random valid/ready toggling, 10k words -> scoreboard matches in order; tx_data[15]=1 for every non-zero word.
- Assert areset with 2 words in flight -> tx_valid=0 immediately. After release, the next input 0x0002 yields tx_shift=14 and no stale words appear.
